// File: rtl/h_pkg.sv
// Shared constants and elaboration helpers for the pipelined OR-reduction tree.
package h_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned FANIN_DEF = 4;

  // Smallest s such that base**s >= n.
  function automatic int unsigned clog_base(input int unsigned n, input int unsigned base);
    int unsigned     s;
    longint unsigned p;
    s = 0;
    p = 1;
    if (base >= 2) begin
      while (p < 64'(n)) begin
        p = p * 64'(base);
        s++;
      end
    end
    return s;
  endfunction

  // Integer power base**e.
  function automatic int unsigned pow_int(input int unsigned base, input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * base;
    return r;
  endfunction

  // Width of a bit index into a WIDTH-bit vector, never less than 1.
  function automatic int unsigned idx_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/h_or_stage.sv
// One registered level of the OR tree: N_IN inputs reduced FANIN at a time.
// H_OR_NWAY_INDEX_EN adds a lowest-set-bit index carried alongside each node.
module h_or_stage #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned FANIN = 4
`ifdef H_OR_NWAY_INDEX_EN
  ,
  parameter int unsigned IW    = 1
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        up_valid,
  input  logic [N_IN-1:0]             up_data,
`ifdef H_OR_NWAY_INDEX_EN
  input  logic [N_IN*IW-1:0]          up_idx,
  output logic [(N_IN/FANIN)*IW-1:0]  dn_idx,
`endif
  output logic                        dn_valid,
  output logic [N_IN/FANIN-1:0]       dn_data
);

  localparam int unsigned N_OUT = N_IN / FANIN;

  logic [N_OUT-1:0] or_next;

  // Each node ORs FANIN adjacent bits of the level below.
  always_comb begin
    or_next = '0;
    for (int unsigned n = 0; n < N_OUT; n++) begin
      or_next[n] = |up_data[n*FANIN +: FANIN];
    end
  end

  // Stage register: load on enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (en) begin
      dn_valid <= up_valid;
      dn_data  <= or_next;
    end
  end

`ifdef H_OR_NWAY_INDEX_EN
  logic [N_OUT*IW-1:0] idx_next;

  // Priority merge: children scanned high to low so the lowest set child wins;
  // an all-zero node keeps index 0.
  always_comb begin
    idx_next = '0;
    for (int unsigned n = 0; n < N_OUT; n++) begin
      for (int unsigned j = FANIN; j > 0; j--) begin
        if (up_data[n*FANIN + j - 1]) begin
          idx_next[n*IW +: IW] = up_idx[(n*FANIN + j - 1)*IW +: IW];
        end
      end
    end
  end

  // Index register, advancing in lockstep with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_idx <= '0;
    end else if (en) begin
      dn_idx <= idx_next;
    end
  end
`endif

endmodule

// File: rtl/h_or_nway_pipe.sv
// Pipelined WIDTH-input OR reduction with valid/ready on both sides and a
// software-cleared sticky flag. Optional macro H_OR_NWAY_INDEX_EN adds out_idx
// (index of the lowest set bit of the delivered vector).
module h_or_nway_pipe
  import h_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned FANIN = FANIN_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          sticky_clr,
  output logic                          sticky
`ifdef H_OR_NWAY_INDEX_EN
  ,
  output logic [idx_width(WIDTH)-1:0]   out_idx
`endif
);

  localparam int unsigned STAGES = clog_base(WIDTH, FANIN);
  localparam int unsigned PADW   = pow_int(FANIN, STAGES);

  if (WIDTH < 2) begin : g_width_chk
    $error("h_or_nway_pipe: WIDTH must be at least 2");
  end
  if (FANIN < 2) begin : g_fanin_chk
    $error("h_or_nway_pipe: FANIN must be at least 2");
  end

  // Zero padding up to a full tree leaves the OR unchanged.
  logic [PADW-1:0] pad_data;
  assign pad_data = PADW'(in_data);

`ifdef H_OR_NWAY_INDEX_EN
  localparam int unsigned IW = idx_width(WIDTH);
  logic [PADW*IW-1:0] pad_idx;
  // Leaf i carries its own position; padded leaves are zero and never win.
  for (genvar i = 0; i < PADW; i++) begin : g_leaf_idx
    assign pad_idx[i*IW +: IW] = IW'(i);
  end
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned N_IN  = pow_int(FANIN, STAGES - k);
    localparam int unsigned N_OUT = N_IN / FANIN;

    logic [N_IN-1:0]  up_data;
    logic             up_valid;
    logic             en;
    logic             vld;
    logic [N_OUT-1:0] dn_data;
`ifdef H_OR_NWAY_INDEX_EN
    logic [N_IN*IW-1:0]  up_idx;
    logic [N_OUT*IW-1:0] dn_idx;
`endif

    if (k == 0) begin : g_src
      assign up_data  = pad_data;
      assign up_valid = in_valid;
`ifdef H_OR_NWAY_INDEX_EN
      assign up_idx   = pad_idx;
`endif
    end else begin : g_src
      assign up_data  = g_st[k-1].dn_data;
      assign up_valid = g_st[k-1].vld;
`ifdef H_OR_NWAY_INDEX_EN
      assign up_idx   = g_st[k-1].dn_idx;
`endif
    end

    // Ready ripples combinationally from the output back to in_ready.
    if (k == STAGES - 1) begin : g_en
      assign en = !vld || out_ready;
    end else begin : g_en
      assign en = !vld || g_st[k+1].en;
    end

    h_or_stage #(
      .N_IN  (N_IN),
      .FANIN (FANIN)
`ifdef H_OR_NWAY_INDEX_EN
      ,
      .IW    (IW)
`endif
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up_valid (up_valid),
      .up_data  (up_data),
`ifdef H_OR_NWAY_INDEX_EN
      .up_idx   (up_idx),
      .dn_idx   (dn_idx),
`endif
      .dn_valid (vld),
      .dn_data  (dn_data)
    );
  end

  assign in_ready  = g_st[0].en;
  assign out       = g_st[STAGES-1].dn_data[0];
  assign out_valid = g_st[STAGES-1].vld;
`ifdef H_OR_NWAY_INDEX_EN
  assign out_idx   = g_st[STAGES-1].dn_idx;
`endif

  logic out_fire;
  assign out_fire = out_valid && out_ready;

  // Sticky: clear first, then OR in any delivered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
    end else begin
      sticky <= (sticky && !sticky_clr) || (out_fire && out);
    end
  end

endmodule

// File: tb/tb_h_or_nway_pipe.sv
// Directed bench for h_or_nway_pipe: default 16/4 instance plus a 10/3 instance.
module tb_h_or_nway_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [15:0] in_data0;
  logic        in_valid0, in_ready0, out0, out_valid0, out_ready0, sticky_clr0, sticky0;
  logic [9:0]  in_data1;
  logic        in_valid1, in_ready1, out1, out_valid1, out_ready1, sticky_clr1, sticky1;
`ifdef H_OR_NWAY_INDEX_EN
  logic [3:0]  idx0, idx1;
`endif

  h_or_nway_pipe #(.WIDTH(16), .FANIN(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out(out0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sticky_clr(sticky_clr0), .sticky(sticky0)
`ifdef H_OR_NWAY_INDEX_EN
    , .out_idx(idx0)
`endif
  );

  h_or_nway_pipe #(.WIDTH(10), .FANIN(3)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out(out1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sticky_clr(sticky_clr1), .sticky(sticky1)
`ifdef H_OR_NWAY_INDEX_EN
    , .out_idx(idx1)
`endif
  );

  typedef struct {
    logic [15:0] din;
    logic        dout;
    logic [3:0]  idx;
  } vec_t;

  vec_t tbl [7];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] low_idx(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  // Present one vector, then idle; returns in the cycle the result is shown.
  task automatic deliver(input logic [15:0] d, input logic exp);
    in_data0  = d;
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    step();
    chk("deliver_valid", 32'(out_valid0), 32'd1);
    chk("deliver_out", 32'(out0), 32'(exp));
  endtask

  initial begin
    tbl[0] = '{16'h0000, 1'b0, 4'd0};
    tbl[1] = '{16'h8000, 1'b1, 4'd15};
    tbl[2] = '{16'h0001, 1'b1, 4'd0};
    tbl[3] = '{16'h0000, 1'b0, 4'd0};
    tbl[4] = '{16'h0C00, 1'b1, 4'd10};
    tbl[5] = '{16'hFFFF, 1'b1, 4'd0};
    tbl[6] = '{16'h0020, 1'b1, 4'd5};

    rst_n = 1'b0;
    in_data0 = '0; in_valid0 = 1'b0; out_ready0 = 1'b1; sticky_clr0 = 1'b0;
    in_data1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1; sticky_clr1 = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_out", 32'(out0), 32'd0);
    chk("rst_sticky", 32'(sticky0), 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_valid_w10", 32'(out_valid1), 32'd0);
`ifdef H_OR_NWAY_INDEX_EN
    chk("rst_idx", 32'(idx0), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // Sticky behaviour
    deliver(16'h0000, 1'b0);
    step();
    chk("sticky_zero", 32'(sticky0), 32'd0);
    deliver(16'h0200, 1'b1);
    step();
    chk("sticky_set", 32'(sticky0), 32'd1);
    deliver(16'h0004, 1'b1);
    sticky_clr0 = 1'b1;
    step();
    sticky_clr0 = 1'b0;
    chk("sticky_clr_and_fire", 32'(sticky0), 32'd1);
    sticky_clr0 = 1'b1;
    step();
    sticky_clr0 = 1'b0;
    chk("sticky_clr_alone", 32'(sticky0), 32'd0);
    out_ready0 = 1'b0;
    in_data0 = 16'hFFFF;
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    chk("sticky_input_fire", 32'(sticky0), 32'd0);
    step();
    chk("sticky_held_no_fire", 32'(sticky0), 32'd0);
    out_ready0 = 1'b1;
    step();
    chk("sticky_after_flush", 32'(sticky0), 32'd1);
    sticky_clr0 = 1'b1;
    step();
    sticky_clr0 = 1'b0;

    // Back-to-back throughput, latency 2
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) begin
        in_data0  = tbl[i].din;
        in_valid0 = 1'b1;
      end else begin
        in_valid0 = 1'b0;
      end
      chk("tp_in_ready", 32'(in_ready0), 32'd1);
      step();
      if (i >= 1) begin
        chk("tp_out_valid", 32'(out_valid0), 32'd1);
        chk("tp_out", 32'(out0), 32'(tbl[i-1].dout));
`ifdef H_OR_NWAY_INDEX_EN
        chk("tp_idx", 32'(idx0), 32'(tbl[i-1].idx));
`endif
      end
    end
    step();
    chk("tp_drained", 32'(out_valid0), 32'd0);

    // Stall, bubble collapse and in-order release
    out_ready0 = 1'b0;
    in_data0 = 16'h0010;
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    step();
    chk("stall_bubble_ready", 32'(in_ready0), 32'd1);
    chk("stall_first_valid", 32'(out_valid0), 32'd1);
    chk("stall_first_out", 32'(out0), 32'd1);
    in_data0 = 16'h0000;
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    chk("stall_full_ready", 32'(in_ready0), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_hold_out", 32'(out0), 32'd1);
      chk("stall_hold_valid", 32'(out_valid0), 32'd1);
      chk("stall_hold_ready", 32'(in_ready0), 32'd0);
    end
    out_ready0 = 1'b1;
    #1;
    chk("stall_ready_comb", 32'(in_ready0), 32'd1);
    step();
    chk("stall_second_valid", 32'(out_valid0), 32'd1);
    chk("stall_second_out", 32'(out0), 32'd0);
    step();
    chk("stall_no_dup", 32'(out_valid0), 32'd0);

    // Reset with two vectors in flight
    out_ready0 = 1'b0;
    in_data0 = 16'hFFFF;
    in_valid0 = 1'b1;
    step();
    in_data0 = 16'h0001;
    step();
    in_valid0 = 1'b0;
    chk("mid_pre_valid", 32'(out_valid0), 32'd1);
    chk("mid_pre_ready", 32'(in_ready0), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid0), 32'd0);
    chk("mid_rst_sticky", 32'(sticky0), 32'd0);
    chk("mid_rst_ready", 32'(in_ready0), 32'd1);
    chk("mid_rst_out", 32'(out0), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_stale", 32'(out_valid0), 32'd0);
    end

    // WIDTH=10, FANIN=3 exhaustive sweep, latency 3
    for (int i = 0; i < 1026; i++) begin
      logic [9:0] v;
      if (i < 1024) begin
        in_data1  = 10'(i);
        in_valid1 = 1'b1;
      end else begin
        in_valid1 = 1'b0;
      end
      step();
      if (i >= 2) begin
        v = 10'(i - 2);
        chk("w10_valid", 32'(out_valid1), 32'd1);
        chk("w10_out", 32'(out1), 32'(|v));
`ifdef H_OR_NWAY_INDEX_EN
        chk("w10_idx", 32'(idx1), 32'(low_idx(16'(v))));
`endif
      end
    end
    step();
    chk("w10_drained", 32'(out_valid1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
